// File: rtl/conv1_psum_collector.sv
// Drain end of the conv1 PE array: paces array_en, keeps psums for valid windows, then applies bias/ReLU/round/saturate.
// Results go through a small first-word-fall-through FIFO onto a valid/ready stream; array_en throttles so nothing is dropped.
module conv1_psum_collector #(
  parameter int PSUM_W     = 20,
  parameter int K          = 3,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int PIPE_LAT   = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              array_en,
  input  logic [PSUM_W-1:0] psum_in,
  input  logic [PSUM_W:0]   bias,
  input  logic [4:0]        shift,
  input  logic              relu_en,
  output logic [7:0]        out_data,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = $clog2(IMG_H);
  localparam int FW   = $clog2(FIFO_DEPTH);
  localparam int NOUT = (IMG_W - K + 1) * (IMG_H - K + 1);
  localparam int OW   = $clog2(NOUT + 1);
  localparam int LW   = $clog2(PIPE_LAT + 1);
  localparam int AW   = PSUM_W + 3;

  localparam logic [CW-1:0] COL_MIN  = CW'(K - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(K - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [FW:0]   EN_MAX   = (FW + 1)'(FIFO_DEPTH - 2);
  localparam logic [LW-1:0] N_FLUSH  = LW'(PIPE_LAT);
  localparam logic [OW-1:0] IDX_LAST = OW'(NOUT - 1);
  localparam logic signed [AW-1:0] SAT_U  = AW'(255);
  localparam logic signed [AW-1:0] SAT_HI = AW'(127);
  localparam logic signed [AW-1:0] SAT_LO = -AW'(128);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t state_q, state_d;

  logic [CW-1:0]       col_q;
  logic [RW-1:0]       row_q;
  logic [LW-1:0]       flush_q;
  logic [PIPE_LAT-1:0] keep_q, keep_shift;
  logic                cap_q;
  logic [OW-1:0]       oidx_q;
  logic [8:0]          mem_q [FIFO_DEPTH];
  logic [FW-1:0]       wr_q, rd_q;
  logic [FW:0]         cnt_q;

  logic push, keep_new, last_pix, pop;
  logic signed [AW-1:0] acc;
  logic [7:0] sat_dat;

  assign array_en = (state_q == S_RUN || (state_q == S_DRAIN && flush_q < N_FLUSH)) && cnt_q <= EN_MAX;
  assign push     = array_en;
  assign keep_new = (state_q == S_RUN) && col_q >= COL_MIN && row_q >= ROW_MIN;
  assign last_pix = col_q == COL_LAST && row_q == ROW_LAST;
  assign out_valid = cnt_q != '0;
  assign pop      = out_valid && out_ready;
  assign out_data = out_valid ? mem_q[rd_q][7:0] : 8'd0;
  assign out_last = out_valid ? mem_q[rd_q][8] : 1'b0;
  assign busy     = state_q != S_IDLE;
  assign done     = state_q == S_DONE;

  // The flag that reaches the end of the line on a push lines up with the psum the array presents after that push.
  always_comb begin
    keep_shift    = '0;
    keep_shift[0] = keep_new;
    for (int i = 1; i < PIPE_LAT; i++) keep_shift[i] = keep_q[i-1];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (push && last_pix) state_d = S_DRAIN;
      S_DRAIN: if (flush_q == N_FLUSH && cnt_q == '0 && !cap_q) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    acc = {{(AW-PSUM_W){psum_in[PSUM_W-1]}}, psum_in} + {{(AW-PSUM_W-1){bias[PSUM_W]}}, bias};
    if (relu_en && acc[AW-1]) acc = '0;
    if (shift != 5'd0) acc = acc + (AW'(1) << (shift - 5'd1));
    acc = acc >>> shift;
    sat_dat = acc[7:0];
    if (relu_en) begin
      if (acc[AW-1])      sat_dat = 8'd0;
      else if (acc > SAT_U) sat_dat = 8'hFF;
    end else begin
      if (acc < SAT_LO)      sat_dat = 8'h80;
      else if (acc > SAT_HI) sat_dat = 8'h7F;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      flush_q <= '0;
      keep_q  <= '0;
      cap_q   <= 1'b0;
      oidx_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cap_q   <= push && keep_shift[PIPE_LAT-1];
      if (state_q == S_IDLE && start) begin
        col_q   <= '0;
        row_q   <= '0;
        flush_q <= '0;
        keep_q  <= '0;
        oidx_q  <= '0;
      end else if (push) begin
        keep_q <= keep_shift;
        if (state_q == S_RUN) begin
          if (col_q == COL_LAST) begin
            col_q <= '0;
            row_q <= (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
          end else begin
            col_q <= col_q + CW'(1);
          end
        end else begin
          flush_q <= flush_q + LW'(1);
        end
      end
      if (cap_q) begin
        wr_q   <= wr_q + FW'(1);
        oidx_q <= oidx_q + OW'(1);
      end
      if (pop) rd_q <= rd_q + FW'(1);
      case ({cap_q, pop})
        2'b10:   cnt_q <= cnt_q + (FW + 1)'(1);
        2'b01:   cnt_q <= cnt_q - (FW + 1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (cap_q) mem_q[wr_q] <= {oidx_q == IDX_LAST, sat_dat};
  end

endmodule

// File: tb/tb_conv1_psum_collector.sv
// Scoreboard bench for conv1_psum_collector on a 5x5 map: a PE-array model feeds psum_in, expected results
// are queued when kept pixels are pushed and compared when the DUT hands them out.
module tb_conv1_psum_collector;
  localparam int PSUM_W = 20;
  localparam int NPIX   = 25;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              array_en;
  logic [PSUM_W-1:0] psum_in = '0;
  logic [PSUM_W:0]   bias = '0;
  logic [4:0]        shift = '0;
  logic              relu_en = 1'b0;
  logic [7:0]        out_data;
  logic              out_last;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              busy;
  logic              done;

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];

  conv1_psum_collector #(
    .PSUM_W(PSUM_W), .K(3), .IMG_W(5), .IMG_H(5), .PIPE_LAT(3), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .array_en(array_en), .psum_in(psum_in),
    .bias(bias), .shift(shift), .relu_en(relu_en), .out_data(out_data), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_calc(input int p, input int b, input int sh, input bit relu);
    longint a;
    a = longint'(p) + longint'(b);
    if (relu && a < 0) a = 0;
    if (sh > 0) a = a + (longint'(1) << (sh - 1));
    a = a >>> sh;
    if (relu) begin
      if (a > 255) a = 255;
    end else begin
      if (a > 127) a = 127;
      if (a < -128) a = -128;
    end
    return int'(a) & 255;
  endfunction

  // rdy_pct < 0: hold out_ready low until the array stalls, then release it.
  task automatic run_map(input int mode, input int cval, input int rdy_pct, input int rst_at);
    int pe[3];
    bit en_prev, stall_prev, done_prev, hold_ready;
    int push_idx, kcnt, ndone, nout, idle_cnt, e, v;
    logic [7:0] hold_d;
    logic hold_l;
    pe = '{0, 0, 0};
    en_prev = 0; stall_prev = 0; done_prev = 0; hold_ready = (rdy_pct < 0);
    push_idx = 0; kcnt = 0; ndone = 0; nout = 0; idle_cnt = 0;
    hold_d = '0; hold_l = 1'b0;
    exp_q.delete();
    psum_in = '0;
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", int'(busy), 1);
    chk("start_en", int'(array_en), 1);
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (en_prev) begin
        v = (mode == 0) ? (push_idx % 100) : cval;
        pe[2] = pe[1]; pe[1] = pe[0]; pe[0] = v;
        push_idx++;
        psum_in = PSUM_W'(pe[2]);
      end
      if (rst_at >= 0 && push_idx == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_vld", int'(out_valid), 0);
        chk("rst_en", int'(array_en), 0);
        chk("rst_busy", int'(busy), 0);
        exp_q.delete();
        return;
      end
      if (stall_prev) begin
        chk("hold_vld", int'(out_valid), 1);
        chk("hold_dat", int'(out_data), int'(hold_d));
        chk("hold_last", int'(out_last), int'(hold_l));
      end
      if (done_prev) begin
        chk("busy_fall", int'(busy), 0);
        break;
      end
      if (hold_ready) begin
        out_ready = 1'b0;
        idle_cnt = array_en ? 0 : idle_cnt + 1;
        if (idle_cnt == 20) begin
          chk("bp_pushes", push_idx, 26);
          chk("bp_vld", int'(out_valid), 1);
          hold_ready = 0;
        end
      end else begin
        out_ready = ($urandom_range(99) < ((rdy_pct < 0) ? 100 : rdy_pct));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_dat", int'(out_data), e & 255);
          chk("out_last", int'(out_last), e >> 8);
        end
        nout++;
      end
      stall_prev = out_valid && !out_ready;
      hold_d = out_data;
      hold_l = out_last;
      if (done) ndone++;
      done_prev = done;
      if (array_en && push_idx < NPIX && (push_idx / 5) >= 2 && (push_idx % 5) >= 2) begin
        v = (mode == 0) ? (push_idx % 100) : cval;
        e = ref_calc(v, int'($signed(bias)), int'(shift), relu_en);
        exp_q.push_back(((kcnt == 8) ? 256 : 0) | e);
        kcnt++;
      end
      en_prev = array_en;
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("n_out", nout, 9);
    chk("n_done", ndone, 1);
    chk("q_empty", exp_q.size(), 0);
  endtask

  task automatic set_cfg(input int b, input int sh, input bit relu);
    bias = (PSUM_W + 1)'(b);
    shift = 5'(sh);
    relu_en = relu;
  endtask

  initial begin
    // reset with random inputs, start asserted mid-reset
    for (int i = 0; i < 3; i++) begin
      psum_in = PSUM_W'($urandom);
      bias = (PSUM_W + 1)'($urandom);
      shift = 5'($urandom_range(20));
      relu_en = 1'($urandom);
      out_ready = 1'($urandom);
      start = (i == 1);
      @(negedge clk);
      chk("rst_en0", int'(array_en), 0);
      chk("rst_vld0", int'(out_valid), 0);
      chk("rst_dat0", int'(out_data), 0);
      chk("rst_last0", int'(out_last), 0);
      chk("rst_busy0", int'(busy), 0);
      chk("rst_done0", int'(done), 0);
    end
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    chk("idle_en", int'(array_en), 0);

    set_cfg(0, 0, 0);
    run_map(0, 0, 100, -1);

    set_cfg(100, 0, 1);
    run_map(1, -300, 100, -1);
    set_cfg(100, 2, 0);
    run_map(1, -300, 100, -1);
    set_cfg(23, 2, 1);
    run_map(1, 1000, 100, -1);
    set_cfg(0, 0, 0);
    run_map(1, -2000, 100, -1);

    set_cfg(0, 0, 0);
    run_map(0, 0, -1, -1);
    run_map(0, 0, 50, -1);

    run_map(0, 0, 100, 15);
    run_map(0, 0, 100, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
